// File: rtl/jk_pkg.sv
// Shared types and constants for the JK excitation driver.
// Excitation cases are indexed by {present q, target t}.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK
    } jk_state_e;

    localparam logic [1:0] EXC_00 = 2'b00;
    localparam logic [1:0] EXC_01 = 2'b01;
    localparam logic [1:0] EXC_10 = 2'b10;
    localparam logic [1:0] EXC_11 = 2'b11;

endpackage

// File: rtl/jk_excitation_driver_if.sv
// Command/feedback bundle between a stimulus source, the driver and a JK flip-flop bank.
interface jk_excitation_driver_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ERR_W = 8
);
    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             done;
    logic             mismatch;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output tgt_valid, tgt_data, q_fb,
        input  tgt_ready, j, k, done, mismatch, err_cnt
    );

    modport slave (
        input  tgt_valid, tgt_data, q_fb,
        output tgt_ready, j, k, done, mismatch, err_cnt
    );
endinterface

// File: rtl/jk_excitation_lut.sv
// One-bit JK excitation table: present q and target t to the J/K pair.
// Don't-care entries are driven with DC_FILL.
module jk_excitation_lut
    import jk_pkg::*;
#(
    parameter bit DC_FILL = 1'b0
) (
    input  logic i_q,
    input  logic i_t,
    output logic o_j,
    output logic o_k
);

    always_comb begin
        o_j = 1'b0;
        o_k = 1'b0;
        case ({i_q, i_t})
            EXC_00: begin o_j = 1'b0;    o_k = DC_FILL; end
            EXC_01: begin o_j = 1'b1;    o_k = DC_FILL; end
            EXC_10: begin o_j = DC_FILL; o_k = 1'b1;    end
            default: begin o_j = DC_FILL; o_k = 1'b0;   end
        endcase
    end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a JK flip-flop bank to a requested word for one clock, then checks the result
// and keeps a saturating count of failed transactions.
module jk_excitation_driver
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter bit          DC_FILL = 1'b0,
    parameter int unsigned ERR_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    jk_excitation_driver_if.slave  bus
);

    jk_state_e        r_state, w_state_next;
    logic [WIDTH-1:0] r_tgt, w_tgt_next;
    logic [WIDTH-1:0] r_j, w_j_next;
    logic [WIDTH-1:0] r_k, w_k_next;
    logic             r_done, w_done_next;
    logic             r_mismatch, w_mismatch_next;
    logic [ERR_W-1:0] r_err_cnt, w_err_cnt_next;

    logic [WIDTH-1:0] w_q_fb;
    logic [WIDTH-1:0] w_tgt_data;
    logic [WIDTH-1:0] w_lut_j;
    logic [WIDTH-1:0] w_lut_k;
    logic             w_accept;

    assign w_q_fb     = bus.q_fb;
    assign w_tgt_data = bus.tgt_data;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lut
        jk_excitation_lut #(
            .DC_FILL (DC_FILL)
        ) u_lut (
            .i_q (w_q_fb[g]),
            .i_t (w_tgt_data[g]),
            .o_j (w_lut_j[g]),
            .o_k (w_lut_k[g])
        );
    end

    // Ready is masked by rst so a source cannot see a handshake while reset is held.
    assign bus.tgt_ready = (r_state == IDLE) && !rst;
    assign w_accept      = bus.tgt_valid && bus.tgt_ready;

    always_comb begin
        w_state_next    = r_state;
        w_tgt_next      = r_tgt;
        w_j_next        = '0;
        w_k_next        = '0;
        w_done_next     = 1'b0;
        w_mismatch_next = 1'b0;
        w_err_cnt_next  = r_err_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_tgt_next   = w_tgt_data;
                    w_j_next     = w_lut_j;
                    w_k_next     = w_lut_k;
                    w_state_next = DRIVE;
                end
            end
            DRIVE: begin
                w_state_next = CHECK;
            end
            CHECK: begin
                w_done_next     = 1'b1;
                w_mismatch_next = (w_q_fb != r_tgt);
                if (w_mismatch_next && (r_err_cnt != {ERR_W{1'b1}})) begin
                    w_err_cnt_next = r_err_cnt + 1'b1;
                end
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tgt      <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_done     <= 1'b0;
            r_mismatch <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_tgt      <= w_tgt_next;
            r_j        <= w_j_next;
            r_k        <= w_k_next;
            r_done     <= w_done_next;
            r_mismatch <= w_mismatch_next;
            r_err_cnt  <= w_err_cnt_next;
        end
    end

    assign bus.j        = r_j;
    assign bus.k        = r_k;
    assign bus.done     = r_done;
    assign bus.mismatch = r_mismatch;
    assign bus.err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench: two drivers (DC_FILL=0 and DC_FILL=1), each closing the loop
// through a behavioural 4-bit JK flip-flop bank.
module tb_jk_excitation_driver;
    import jk_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stuck0 = 1'b0;
    logic [3:0] bank0_q, bank1_q;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    jk_excitation_driver_if #(.WIDTH(4), .ERR_W(8)) b0 ();
    jk_excitation_driver_if #(.WIDTH(4), .ERR_W(8)) b1 ();

    jk_excitation_driver #(.WIDTH(4), .DC_FILL(1'b0), .ERR_W(8)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    jk_excitation_driver #(.WIDTH(4), .DC_FILL(1'b1), .ERR_W(8)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    // Behavioural JK banks sharing clk/rst with the drivers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank0_q <= 4'b0000;
            bank1_q <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                case ({b0.j[i], b0.k[i]})
                    2'b10:   bank0_q[i] <= 1'b1;
                    2'b01:   bank0_q[i] <= 1'b0;
                    2'b11:   bank0_q[i] <= ~bank0_q[i];
                    default: bank0_q[i] <= bank0_q[i];
                endcase
                case ({b1.j[i], b1.k[i]})
                    2'b10:   bank1_q[i] <= 1'b1;
                    2'b01:   bank1_q[i] <= 1'b0;
                    2'b11:   bank1_q[i] <= ~bank1_q[i];
                    default: bank1_q[i] <= bank1_q[i];
                endcase
            end
        end
    end

    assign b0.q_fb = bank0_q & ~{3'b000, stuck0};
    assign b1.q_fb = bank1_q;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction: accept, DRIVE, CHECK, ending in the done cycle.
    task automatic run_txn(input bit sel, input logic [3:0] t, input logic [3:0] ej,
                           input logic [3:0] ek, input string tag);
        int waited = 0;
        while (!(sel ? b1.tgt_ready : b0.tgt_ready) && waited < 10) begin
            tick();
            waited++;
        end
        check_val({tag, "_ready"}, 32'(sel ? b1.tgt_ready : b0.tgt_ready), 32'd1);
        if (sel) begin b1.tgt_valid = 1'b1; b1.tgt_data = t; end
        else     begin b0.tgt_valid = 1'b1; b0.tgt_data = t; end
        tick();
        b0.tgt_valid = 1'b0;
        b1.tgt_valid = 1'b0;
        check_val({tag, "_busy"}, 32'(sel ? b1.tgt_ready : b0.tgt_ready), 32'd0);
        check_val({tag, "_j"}, 32'(sel ? b1.j : b0.j), 32'(ej));
        check_val({tag, "_k"}, 32'(sel ? b1.k : b0.k), 32'(ek));
        tick();
        check_val({tag, "_q"}, 32'(sel ? bank1_q : bank0_q), 32'(t));
        check_val({tag, "_jk_clr"}, 32'(sel ? {b1.j, b1.k} : {b0.j, b0.k}), 32'd0);
        tick();
        check_val({tag, "_done"}, 32'(sel ? b1.done : b0.done), 32'd1);
        check_val({tag, "_mis"}, 32'(sel ? b1.mismatch : b0.mismatch), 32'd0);
    endtask

    logic [3:0] seq_t [4] = '{4'b1100, 4'b0101, 4'b1010, 4'b0000};
    logic [3:0] seq_j [4] = '{4'b1100, 4'b0001, 4'b1010, 4'b0000};
    logic [3:0] seq_k [4] = '{4'b0011, 4'b1000, 4'b0101, 4'b1010};

    initial begin
        int dones;
        b0.tgt_valid = 1'b0; b0.tgt_data = '0;
        b1.tgt_valid = 1'b0; b1.tgt_data = '0;

        // 1: reset values
        #2;
        check_val("rst_jk", 32'({b0.j, b0.k}), 32'd0);
        check_val("rst_done", 32'(b0.done), 32'd0);
        check_val("rst_err", 32'(b0.err_cnt), 32'd0);
        check_val("rst_ready", 32'(b0.tgt_ready), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_val("rel_ready", 32'(b0.tgt_ready), 32'd1);
        check_val("rel_q", 32'(bank0_q), 32'd0);

        // 2, 3: DC_FILL=0 transitions
        run_txn(1'b0, 4'b1010, 4'b1010, 4'b0000, "t2");
        run_txn(1'b0, 4'b0110, 4'b0100, 4'b1000, "t3");

        // 4: DC_FILL=1 bank, reach 0110 then request the same word again
        run_txn(1'b1, 4'b0110, 4'b0110, 4'b1111, "t4a");
        run_txn(1'b1, 4'b0110, 4'b0110, 4'b1001, "t4b");

        // 5: bit 0 of feedback stuck low, err_cnt must saturate
        stuck0 = 1'b1;
        dones  = 0;
        for (int i = 0; i < 300; i++) begin
            b0.tgt_valid = 1'b1;
            b0.tgt_data  = 4'b1111;
            tick();
            b0.tgt_valid = 1'b0;
            tick();
            tick();
            if (b0.done && b0.mismatch) dones++;
            if (i == 0) begin
                check_val("t5_mis", 32'(b0.mismatch), 32'd1);
                check_val("t5_err1", 32'(b0.err_cnt), 32'd1);
            end
        end
        check_val("t5_count", 32'(dones), 32'd300);
        check_val("t5_sat", 32'(b0.err_cnt), 32'd255);
        tick();
        check_val("t5_mis_low", 32'(b0.mismatch), 32'd0);
        stuck0 = 1'b0;

        // 6: reset during DRIVE drops the transaction
        b0.tgt_valid = 1'b1;
        b0.tgt_data  = 4'b0000;
        tick();
        b0.tgt_valid = 1'b0;
        check_val("t6_k", 32'(b0.k), 32'hF);
        rst = 1'b1;
        #1;
        check_val("t6_jk", 32'({b0.j, b0.k}), 32'd0);
        check_val("t6_err", 32'(b0.err_cnt), 32'd0);
        #1;
        rst = 1'b0;
        tick();
        check_val("t6_nodone", 32'(b0.done), 32'd0);
        tick();
        check_val("t6_nodone2", 32'(b0.done), 32'd0);
        run_txn(1'b0, 4'b0011, 4'b0011, 4'b0000, "t6b");

        // 7: tgt_valid held high across four back-to-back targets
        b0.tgt_valid = 1'b1;
        b0.tgt_data  = seq_t[0];
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("t7_busy", 32'(b0.tgt_ready), 32'd0);
            check_val("t7_j", 32'(b0.j), 32'(seq_j[i]));
            check_val("t7_k", 32'(b0.k), 32'(seq_k[i]));
            if (i < 3) b0.tgt_data = seq_t[i+1];
            else       b0.tgt_valid = 1'b0;
            tick();
            check_val("t7_early", 32'(b0.done), 32'd0);
            tick();
            check_val("t7_done", 32'(b0.done), 32'd1);
            check_val("t7_mis", 32'(b0.mismatch), 32'd0);
            check_val("t7_q", 32'(bank0_q), 32'(seq_t[i]));
            check_val("t7_ready", 32'(b0.tgt_ready), 32'd1);
        end
        tick();
        check_val("t7_idle", 32'(b0.tgt_ready), 32'd1);
        check_val("t7_q_hold", 32'(bank0_q), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
